joypad_serializer_n: RTL and testbench

- Parametrised successor to the fixed two-port joypad shift logic.
- Serialises NUM_PORTS controller button vectors to the GAMETANK core's joypad inputs.
- Adds per-port runtime turbo masks, configurable shift length and fill value, and per-port read counters.
- Sits between the controller-merge logic (joyN = pad | hid | usb) and the GAMETANK core's joypad_out/joypad_clock/joypadN_data pins.

---
 rtl/joypad_serializer_n_pkg.sv | 32 +++
 rtl/joypad_serializer_n_turbo.sv | 67 ++++++
 rtl/joypad_serializer_n.sv | 95 +++++++++
 tb/tb_joypad_serializer_n.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/joypad_serializer_n_pkg.sv
// Shared constants for the joypad serializer.
// Contents:
//   - GAMETANK button indices (BTN_*).
//   - Default button-vector width and turbo half-period.
//   - A helper that sizes counters so they are never zero bits wide.
package joypad_serializer_n_pkg;

    // GAMETANK button layout; bit index inside a JOY_BTN_WIDTH vector.
    localparam int unsigned BTN_B      = 0;
    localparam int unsigned BTN_Y      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DN     = 5;
    localparam int unsigned BTN_LT     = 6;
    localparam int unsigned BTN_RT     = 7;
    localparam int unsigned BTN_A      = 8;
    localparam int unsigned BTN_X      = 9;
    localparam int unsigned BTN_L      = 10;
    localparam int unsigned BTN_R      = 11;

    localparam int unsigned JOY_BTN_WIDTH = 12;

    // About 30 Hz turbo at a 21.477 MHz core clock.
    localparam int unsigned TURBO_HALF_DEFAULT = 357_000;

    // Width needed to count 0..n-1, at least one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/joypad_serializer_n_turbo.sv
// Per-port turbo generator.
// A square-wave phase gates every button whose mask bit is set.
//
// Ports:
//   clk_i     core clock
//   resetn_i  asynchronous active-low reset
//   btn_i     raw buttons, 1 = pressed
//   mask_i    per-button turbo enable
//   eff_o     effective buttons for the serialised bits [SHIFT_BITS-1:0]
//
// Phase behaviour:
//   - While no masked button is held, the phase sits "on" and the counter is 0.
//   - A fresh press is therefore reported pressed at once.
//   - It stays pressed for TURBO_HALF cycles, then alternates.
module joypad_serializer_n_turbo
    import joypad_serializer_n_pkg::*;
#(
    parameter int unsigned BTN_WIDTH  = JOY_BTN_WIDTH,
    parameter int unsigned SHIFT_BITS = 8,
    parameter int unsigned TURBO_HALF = TURBO_HALF_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic [BTN_WIDTH-1:0]  btn_i,
    input  logic [BTN_WIDTH-1:0]  mask_i,
    output logic [SHIFT_BITS-1:0] eff_o
);

    localparam int unsigned TcW = cnt_width(TURBO_HALF);
    localparam logic [TcW-1:0] TcLast = TcW'(TURBO_HALF - 1);

    logic           held;
    logic [TcW-1:0] cnt_q, cnt_d;
    logic           phase_q, phase_d;

    // Buttons above SHIFT_BITS still count here; they never reach the serial data.
    assign held = |(btn_i & mask_i);

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!held) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == TcLast) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + TcW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    // Unmasked buttons pass straight through; masked ones only while the phase is on.
    assign eff_o = btn_i[SHIFT_BITS-1:0]
                 & (~mask_i[SHIFT_BITS-1:0] | {SHIFT_BITS{phase_q}});

endmodule

// File: rtl/joypad_serializer_n.sv
// Serialises NUM_PORTS controller button vectors onto the GAMETANK joypad pins.
//
// Ports:
//   clk_i         core clock (~21.477 MHz)
//   resetn_i      asynchronous active-low reset
//   joy_btns_i    raw buttons; port p at [p*BTN_WIDTH +: BTN_WIDTH], 1 = pressed
//   turbo_mask_i  per-button turbo enable, same packing
//   strobe_i      shared load strobe (joypad_out[0])
//   joy_clk_i     per-port serial clock; each falling edge shifts one bit
//   joy_data_o    per-port serial data, bit 0 of the shift register
//   read_cnt_o    per-port shifts since last strobe, saturating at SHIFT_BITS
//   overread_o    per-port flag, set once SHIFT_BITS shifts have happened
//
// Strobe and shift behaviour:
//   - Strobe has priority over a coincident falling edge: it loads, with no shift or count.
//   - Bits shifted in at the top are FILL_VALUE.
//   - A fully read port therefore keeps returning FILL_VALUE.
module joypad_serializer_n
    import joypad_serializer_n_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned BTN_WIDTH  = JOY_BTN_WIDTH,
    parameter int unsigned SHIFT_BITS = 8,
    parameter logic        FILL_VALUE = 1'b1,
    parameter int unsigned TURBO_HALF = TURBO_HALF_DEFAULT,
    parameter int unsigned CNT_W      = $clog2(SHIFT_BITS + 1)
) (
    input  logic                           clk_i,
    input  logic                           resetn_i,
    input  logic [NUM_PORTS*BTN_WIDTH-1:0] joy_btns_i,
    input  logic [NUM_PORTS*BTN_WIDTH-1:0] turbo_mask_i,
    input  logic                           strobe_i,
    input  logic [NUM_PORTS-1:0]           joy_clk_i,
    output logic [NUM_PORTS-1:0]           joy_data_o,
    output logic [NUM_PORTS*CNT_W-1:0]     read_cnt_o,
    output logic [NUM_PORTS-1:0]           overread_o
);

    localparam logic [CNT_W-1:0] CntFull = CNT_W'(SHIFT_BITS);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [SHIFT_BITS-1:0] eff;
        logic [SHIFT_BITS-1:0] shift_q, shift_d;
        logic [CNT_W-1:0]      cnt_q, cnt_d;
        logic                  last_clk_q;
        logic                  fall;

        joypad_serializer_n_turbo #(
            .BTN_WIDTH  (BTN_WIDTH),
            .SHIFT_BITS (SHIFT_BITS),
            .TURBO_HALF (TURBO_HALF)
        ) u_turbo (
            .clk_i    (clk_i),
            .resetn_i (resetn_i),
            .btn_i    (joy_btns_i[p*BTN_WIDTH +: BTN_WIDTH]),
            .mask_i   (turbo_mask_i[p*BTN_WIDTH +: BTN_WIDTH]),
            .eff_o    (eff)
        );

        // Registered edge detect; reset clears last_clk so a low first sample is not an edge.
        assign fall = last_clk_q & ~joy_clk_i[p];

        always_comb begin
            shift_d = shift_q;
            cnt_d   = cnt_q;
            if (strobe_i) begin
                shift_d = eff;
                cnt_d   = '0;
            end else if (fall) begin
                // Right shift with FILL_VALUE entering at the MSB.
                shift_d = SHIFT_BITS'({FILL_VALUE, shift_q} >> 1);
                if (cnt_q != CntFull) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk_i or negedge resetn_i) begin
            if (!resetn_i) begin
                shift_q    <= '0;
                cnt_q      <= '0;
                last_clk_q <= 1'b0;
            end else begin
                shift_q    <= shift_d;
                cnt_q      <= cnt_d;
                last_clk_q <= joy_clk_i[p];
            end
        end

        assign joy_data_o[p]                  = shift_q[0];
        assign read_cnt_o[p*CNT_W +: CNT_W]   = cnt_q;
        assign overread_o[p]                  = (cnt_q == CntFull);
    end

endmodule

// File: tb/tb_joypad_serializer_n.sv
module tb_joypad_serializer_n;

    localparam int NP = 2;
    localparam int BW = 12;
    localparam int SB = 8;
    localparam int TH = 4;
    localparam int CW = 4;
    localparam int TW = NP * BW;
    localparam logic FILL = 1'b1;

    logic            clk = 1'b0;
    logic            resetn;
    logic [TW-1:0]   btns;
    logic [TW-1:0]   mask;
    logic            strobe;
    logic [NP-1:0]   jclk;
    logic [NP-1:0]   jdata;
    logic [NP*CW-1:0] rcnt;
    logic [NP-1:0]   ovr;

    int total = 0;
    int bad   = 0;

    // Reference model: latched word, read position, clock history, turbo hold time.
    logic [SB-1:0] m_word [NP];
    int            m_cnt  [NP];
    logic          m_prev [NP];
    int            m_held [NP];

    always #5 clk = ~clk;

    joypad_serializer_n #(
        .NUM_PORTS  (NP),
        .BTN_WIDTH  (BW),
        .SHIFT_BITS (SB),
        .FILL_VALUE (FILL),
        .TURBO_HALF (TH),
        .CNT_W      (CW)
    ) dut (
        .clk_i        (clk),
        .resetn_i     (resetn),
        .joy_btns_i   (btns),
        .turbo_mask_i (mask),
        .strobe_i     (strobe),
        .joy_clk_i    (jclk),
        .joy_data_o   (jdata),
        .read_cnt_o   (rcnt),
        .overread_o   (ovr)
    );

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_word[p] = '0;
            m_cnt[p]  = 0;
            m_prev[p] = 1'b0;
            m_held[p] = 0;
        end
    endtask

    // Turbo phase from hold time: on during even TH-long windows since the press.
    function automatic logic [SB-1:0] m_eff(input int p);
        logic [BW-1:0] b;
        logic [BW-1:0] k;
        logic          on;
        b  = btns[p*BW +: BW];
        k  = mask[p*BW +: BW];
        on = ((m_held[p] / TH) % 2) == 0;
        return b[SB-1:0] & (~k[SB-1:0] | {SB{on}});
    endfunction

    function automatic logic exp_data(input int p);
        if (m_cnt[p] < SB) return m_word[p][m_cnt[p]];
        return FILL;
    endfunction

    // Advance one clock; the model consumes the inputs present at the edge.
    task automatic tick();
        @(posedge clk);
        if (!resetn) begin
            model_reset();
        end else begin
            for (int p = 0; p < NP; p++) begin
                logic [SB-1:0] e;
                logic [BW-1:0] b;
                logic [BW-1:0] k;
                e = m_eff(p);
                b = btns[p*BW +: BW];
                k = mask[p*BW +: BW];
                if (strobe) begin
                    m_word[p] = e;
                    m_cnt[p]  = 0;
                end else if (m_prev[p] && !jclk[p]) begin
                    if (m_cnt[p] < SB) m_cnt[p]++;
                end
                m_prev[p] = jclk[p];
                m_held[p] = (|(b & k)) ? m_held[p] + 1 : 0;
            end
        end
        #1;
    endtask

    task automatic shift_port(input int p);
        jclk[p] = 1'b1;
        tick();
        jclk[p] = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        btns   = TW'($urandom);
        mask   = '0;
        strobe = 1'b1;
        jclk   = '1;
        repeat (3) tick();
        total++;
        if (jdata !== '0) begin
            bad++;
            $display("FAIL reset_data: got %b want 0", jdata);
        end
        total++;
        if (rcnt !== '0) begin
            bad++;
            $display("FAIL reset_cnt: got %h want 0", rcnt);
        end
        total++;
        if (ovr !== '0) begin
            bad++;
            $display("FAIL reset_ovr: got %b want 0", ovr);
        end
        strobe = 1'b0;
        jclk   = '0;
        resetn = 1'b1;
        repeat (2) tick();
        total++;
        if (jdata !== '0 || rcnt !== '0 || ovr !== '0) begin
            bad++;
            $display("FAIL post_reset: data=%b cnt=%h ovr=%b want all 0", jdata, rcnt, ovr);
        end
    endtask

    task automatic test_basic_read();
        logic [8:0] seq;
        seq = 9'b1_1010_0101;
        mask = '0;
        btns = '0;
        btns[BW-1:0]  = 12'h0A5;
        btns[TW-1:BW] = 12'h3C6;
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        for (int i = 0; i <= SB; i++) begin
            total++;
            if (jdata[0] !== seq[i]) begin
                bad++;
                $display("FAIL basic_bit%0d: got %b want %b", i, jdata[0], seq[i]);
            end
            total++;
            if (jdata[0] !== exp_data(0)) begin
                bad++;
                $display("FAIL basic_model%0d: got %b want %b", i, jdata[0], exp_data(0));
            end
            if (i < SB) shift_port(0);
        end
        shift_port(0);
        total++;
        if (rcnt[CW-1:0] !== 4'd8 || ovr[0] !== 1'b1 || jdata[0] !== FILL) begin
            bad++;
            $display("FAIL basic_sat: cnt=%0d ovr=%b data=%b want 8 1 1",
                     rcnt[CW-1:0], ovr[0], jdata[0]);
        end
        total++;
        if (rcnt[2*CW-1:CW] !== 4'd0 || ovr[1] !== 1'b0 || jdata[1] !== exp_data(1)) begin
            bad++;
            $display("FAIL basic_port1: cnt=%0d ovr=%b data=%b want 0 0 %b",
                     rcnt[2*CW-1:CW], ovr[1], jdata[1], exp_data(1));
        end
    endtask

    task automatic test_strobe_priority();
        shift_port(1);
        btns[TW-1:BW] = 12'h0F3;
        jclk[1] = 1'b1;
        tick();
        jclk[1] = 1'b0;
        strobe  = 1'b1;
        tick();
        strobe = 1'b0;
        total++;
        if (rcnt[2*CW-1:CW] !== 4'd0) begin
            bad++;
            $display("FAIL prio_cnt: got %0d want 0", rcnt[2*CW-1:CW]);
        end
        total++;
        if (jdata[1] !== 1'b1 || jdata[1] !== exp_data(1)) begin
            bad++;
            $display("FAIL prio_data: got %b want 1", jdata[1]);
        end
        shift_port(1);
        total++;
        if (jdata[1] !== 1'b1 || rcnt[2*CW-1:CW] !== 4'd1) begin
            bad++;
            $display("FAIL prio_next: data=%b cnt=%0d want 1 1", jdata[1], rcnt[2*CW-1:CW]);
        end
    endtask

    task automatic test_turbo();
        btns = '0;
        mask = '0;
        mask[0] = 1'b1;
        strobe  = 1'b1;
        repeat (2) tick();
        btns[0] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            logic want;
            want = ((c / TH) % 2) == 0;
            tick();
            total++;
            if (jdata[0] !== want || jdata[0] !== exp_data(0)) begin
                bad++;
                $display("FAIL turbo_c%0d: got %b want %b", c, jdata[0], want);
            end
        end
        btns[0] = 1'b0;
        tick();
        btns[0] = 1'b1;
        tick();
        total++;
        if (jdata[0] !== 1'b1) begin
            bad++;
            $display("FAIL turbo_repress: got %b want 1", jdata[0]);
        end
        strobe = 1'b0;
        mask   = '0;
        tick();
    endtask

    task automatic test_strobe_held();
        strobe = 1'b1;
        for (int c = 0; c < 20; c++) begin
            btns = TW'($urandom);
            jclk = NP'($urandom);
            tick();
            for (int p = 0; p < NP; p++) begin
                total++;
                if (jdata[p] !== exp_data(p) || rcnt[p*CW +: CW] !== 4'd0) begin
                    bad++;
                    $display("FAIL held_c%0d_p%0d: data=%b cnt=%0d want %b 0",
                             c, p, jdata[p], rcnt[p*CW +: CW], exp_data(p));
                end
            end
        end
        strobe = 1'b0;
        jclk   = '0;
        tick();
    endtask

    task automatic test_async_reset();
        btns   = TW'($urandom);
        mask   = '0;
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        repeat (3) shift_port(0);
        jclk[0] = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        total++;
        if (jdata !== '0 || rcnt !== '0 || ovr !== '0) begin
            bad++;
            $display("FAIL async_reset: data=%b cnt=%h ovr=%b want all 0", jdata, rcnt, ovr);
        end
        tick();
        resetn = 1'b1;
        jclk   = '0;
        tick();
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        for (int i = 0; i < SB; i++) begin
            total++;
            if (jdata[0] !== exp_data(0) || rcnt[CW-1:0] !== CW'(m_cnt[0])) begin
                bad++;
                $display("FAIL reread_%0d: data=%b cnt=%0d want %b %0d",
                         i, jdata[0], rcnt[CW-1:0], exp_data(0), m_cnt[0]);
            end
            shift_port(0);
        end
        total++;
        if (ovr[0] !== 1'b1 || jdata[0] !== FILL) begin
            bad++;
            $display("FAIL reread_end: ovr=%b data=%b want 1 1", ovr[0], jdata[0]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) btns = TW'($urandom);
            if ($urandom_range(0, 15) == 0) mask = TW'($urandom & $urandom & $urandom);
            strobe = ($urandom_range(0, 9) == 0);
            jclk   = NP'($urandom);
            tick();
            for (int p = 0; p < NP; p++) begin
                total++;
                if (jdata[p] !== exp_data(p)) begin
                    bad++;
                    $display("FAIL rand_data c%0d p%0d: got %b want %b",
                             c, p, jdata[p], exp_data(p));
                end
                total++;
                if (rcnt[p*CW +: CW] !== CW'(m_cnt[p]) || ovr[p] !== (m_cnt[p] == SB)) begin
                    bad++;
                    $display("FAIL rand_cnt c%0d p%0d: cnt=%0d ovr=%b want %0d %b",
                             c, p, rcnt[p*CW +: CW], ovr[p], m_cnt[p], m_cnt[p] == SB);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        resetn = 1'b0;
        btns   = '0;
        mask   = '0;
        strobe = 1'b0;
        jclk   = '0;
        test_reset();
        test_basic_read();
        test_strobe_priority();
        test_turbo();
        test_strobe_held();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
